// File: rtl/sec_fault_campaign_ctrl.sv
// Single-bit fault-injection campaign sequencer for the SEC(12,8) path: one fault-free
// baseline step, then one injected fault per codeword position, each checked at the decoder.
module sec_fault_campaign_ctrl #(
    parameter int CODE_W  = 12,
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 4,
    parameter int DEC_LAT = 1,
    parameter int CNT_W   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [DATA_W-1:0] ref_data,
    input  logic [DATA_W-1:0] dec_data,
    input  logic              dec_err,
    output logic [DATA_W-1:0] enc_data,
    output logic              fault_en,
    output logic [ADDR_W-1:0] fault_bit_addr,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  pass_cnt,
    output logic [CNT_W-1:0]  fail_cnt,
    output logic [CODE_W-1:0] fail_mask,
    output logic              baseline_fail
);

    localparam int STEP_W = $clog2(CODE_W + 1);
    localparam int WAIT_W = (DEC_LAT > 1) ? $clog2(DEC_LAT) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_APPLY,
        S_WAIT,
        S_CHECK,
        S_DONE
    } state_t;

    state_t              r_state, w_state_nx;
    logic [STEP_W-1:0]   r_step, w_step_nx;
    logic [WAIT_W-1:0]   r_wait, w_wait_nx;
    logic [DATA_W-1:0]   r_enc, w_enc_nx;
    logic                r_fen, w_fen_nx;
    logic [ADDR_W-1:0]   r_addr, w_addr_nx;
    logic                r_busy, w_busy_nx;
    logic                r_done, w_done_nx;
    logic [CNT_W-1:0]    r_pass, w_pass_nx;
    logic [CNT_W-1:0]    r_fail, w_fail_nx;
    logic [CODE_W-1:0]   r_mask, w_mask_nx;
    logic                r_base, w_base_nx;
    logic                w_step_ok;

    assign enc_data       = r_enc;
    assign fault_en       = r_fen;
    assign fault_bit_addr = r_addr;
    assign busy           = r_busy;
    assign done           = r_done;
    assign pass_cnt       = r_pass;
    assign fail_cnt       = r_fail;
    assign fail_mask      = r_mask;
    assign baseline_fail  = r_base;

    // Baseline step expects a clean syndrome; injected steps expect the error flag.
    assign w_step_ok = (dec_data == r_enc) && (dec_err == (r_step != '0));

    always_comb begin
        w_state_nx = r_state;
        w_step_nx  = r_step;
        w_wait_nx  = r_wait;
        w_enc_nx   = r_enc;
        w_fen_nx   = r_fen;
        w_addr_nx  = r_addr;
        w_busy_nx  = r_busy;
        w_done_nx  = 1'b0;
        w_pass_nx  = r_pass;
        w_fail_nx  = r_fail;
        w_mask_nx  = r_mask;
        w_base_nx  = r_base;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_enc_nx   = ref_data;
                    w_pass_nx  = '0;
                    w_fail_nx  = '0;
                    w_mask_nx  = '0;
                    w_base_nx  = 1'b0;
                    w_step_nx  = '0;
                    w_fen_nx   = 1'b0;
                    w_addr_nx  = '0;
                    w_busy_nx  = 1'b1;
                    w_state_nx = S_APPLY;
                end
            end
            S_APPLY, S_WAIT, S_CHECK: begin
                if (abort) begin
                    w_fen_nx   = 1'b0;
                    w_addr_nx  = '0;
                    w_busy_nx  = 1'b0;
                    w_state_nx = S_IDLE;
                end else if (r_state == S_APPLY) begin
                    w_wait_nx  = '0;
                    w_state_nx = (DEC_LAT == 0) ? S_CHECK : S_WAIT;
                end else if (r_state == S_WAIT) begin
                    if (r_wait == WAIT_W'(DEC_LAT - 1)) begin
                        w_state_nx = S_CHECK;
                    end else begin
                        w_wait_nx = r_wait + WAIT_W'(1);
                    end
                end else begin
                    if (w_step_ok) begin
                        w_pass_nx = r_pass + CNT_W'(1);
                    end else begin
                        w_fail_nx = r_fail + CNT_W'(1);
                        if (r_step == '0) begin
                            w_base_nx = 1'b1;
                        end
                        for (int unsigned i = 0; i < CODE_W; i++) begin
                            if (r_step == STEP_W'(i + 1)) begin
                                w_mask_nx[i] = 1'b1;
                            end
                        end
                    end
                    if (r_step == STEP_W'(CODE_W)) begin
                        w_fen_nx   = 1'b0;
                        w_addr_nx  = '0;
                        w_done_nx  = 1'b1;
                        w_state_nx = S_DONE;
                    end else begin
                        // Step s+1 injects at position s, i.e. the current step index.
                        w_step_nx  = r_step + STEP_W'(1);
                        w_fen_nx   = 1'b1;
                        w_addr_nx  = ADDR_W'(r_step);
                        w_state_nx = S_APPLY;
                    end
                end
            end
            S_DONE: begin
                w_busy_nx  = 1'b0;
                w_state_nx = S_IDLE;
            end
            default: begin
                w_fen_nx   = 1'b0;
                w_busy_nx  = 1'b0;
                w_state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_step  <= '0;
            r_wait  <= '0;
            r_enc   <= '0;
            r_fen   <= 1'b0;
            r_addr  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_pass  <= '0;
            r_fail  <= '0;
            r_mask  <= '0;
            r_base  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_step  <= w_step_nx;
            r_wait  <= w_wait_nx;
            r_enc   <= w_enc_nx;
            r_fen   <= w_fen_nx;
            r_addr  <= w_addr_nx;
            r_busy  <= w_busy_nx;
            r_done  <= w_done_nx;
            r_pass  <= w_pass_nx;
            r_fail  <= w_fail_nx;
            r_mask  <= w_mask_nx;
            r_base  <= w_base_nx;
        end
    end

endmodule

// File: tb/tb_sec_fault_campaign_ctrl.sv
// Bench for sec_fault_campaign_ctrl: three instances (DEC_LAT 1, 3, 0) driving a behavioural
// decoder with selectable defects, checked every cycle against a timeline model.
module tb_sec_fault_campaign_ctrl;

    localparam int CW = 12;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] start;
    logic       abort;
    logic [7:0] ref_data;
    int         mode;

    logic [7:0]  enc[3];
    logic [7:0]  dec_data[3];
    logic        dec_err[3];
    logic        fen[3];
    logic [3:0]  addr[3];
    logic        busy[3];
    logic        done[3];
    logic [3:0]  pc[3];
    logic [3:0]  fc[3];
    logic [11:0] mask[3];
    logic        base[3];

    int checks = 0;
    int errors = 0;
    int done_cnt[3];

    always #5 clk = ~clk;

    sec_fault_campaign_ctrl #(.CODE_W(12), .DATA_W(8), .ADDR_W(4), .DEC_LAT(1), .CNT_W(4)) u_lat1 (
        .clk(clk), .rst_n(rst_n), .start(start[0]), .abort(abort), .ref_data(ref_data),
        .dec_data(dec_data[0]), .dec_err(dec_err[0]), .enc_data(enc[0]), .fault_en(fen[0]),
        .fault_bit_addr(addr[0]), .busy(busy[0]), .done(done[0]), .pass_cnt(pc[0]),
        .fail_cnt(fc[0]), .fail_mask(mask[0]), .baseline_fail(base[0]));

    sec_fault_campaign_ctrl #(.CODE_W(12), .DATA_W(8), .ADDR_W(4), .DEC_LAT(3), .CNT_W(4)) u_lat3 (
        .clk(clk), .rst_n(rst_n), .start(start[1]), .abort(abort), .ref_data(ref_data),
        .dec_data(dec_data[1]), .dec_err(dec_err[1]), .enc_data(enc[1]), .fault_en(fen[1]),
        .fault_bit_addr(addr[1]), .busy(busy[1]), .done(done[1]), .pass_cnt(pc[1]),
        .fail_cnt(fc[1]), .fail_mask(mask[1]), .baseline_fail(base[1]));

    sec_fault_campaign_ctrl #(.CODE_W(12), .DATA_W(8), .ADDR_W(4), .DEC_LAT(0), .CNT_W(4)) u_lat0 (
        .clk(clk), .rst_n(rst_n), .start(start[2]), .abort(abort), .ref_data(ref_data),
        .dec_data(dec_data[2]), .dec_err(dec_err[2]), .enc_data(enc[2]), .fault_en(fen[2]),
        .fault_bit_addr(addr[2]), .busy(busy[2]), .done(done[2]), .pass_cnt(pc[2]),
        .fail_cnt(fc[2]), .fail_mask(mask[2]), .baseline_fail(base[2]));

    // Decoder: ideal SEC corrects everything; mode 1 miscorrects position 5, mode 2 has dec_err stuck at 1.
    logic [7:0] raw_d[3];
    logic       raw_e[3];
    always_comb begin
        for (int k = 0; k < 3; k++) begin
            raw_d[k] = enc[k] ^ ((mode == 1 && fen[k] && addr[k] == 4'd5) ? 8'h01 : 8'h00);
            raw_e[k] = fen[k] | (mode == 2);
        end
    end

    logic [7:0] d1_q;
    logic       e1_q;
    logic [7:0] d3_q[3];
    logic       e3_q[3];
    always_ff @(posedge clk) begin
        d1_q    <= raw_d[0];
        e1_q    <= raw_e[0];
        d3_q[0] <= raw_d[1];
        e3_q[0] <= raw_e[1];
        d3_q[1] <= d3_q[0];
        e3_q[1] <= e3_q[0];
        d3_q[2] <= d3_q[1];
        e3_q[2] <= e3_q[1];
    end
    assign dec_data[0] = d1_q;
    assign dec_err[0]  = e1_q;
    assign dec_data[1] = d3_q[2];
    assign dec_err[1]  = e3_q[2];
    assign dec_data[2] = raw_d[2];
    assign dec_err[2]  = raw_e[2];

    function automatic int lat(input int k);
        return (k == 0) ? 1 : ((k == 1) ? 3 : 0);
    endfunction

    function automatic bit step_ok(input int md, input int s);
        if (md == 1 && s == 6) return 1'b0;
        if (md == 2 && s == 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: m_t counts clock edges since the accepted start (1 = first cycle after it).
    bit         m_act[3];
    int         m_t[3];
    int         m_md[3];
    int         m_pass[3];
    int         m_fail[3];
    logic [11:0] m_mask[3];
    bit         m_base[3];
    logic [7:0] m_ref[3];

    initial begin
        for (int k = 0; k < 3; k++) begin
            m_act[k] = 0; m_t[k] = 0; m_md[k] = 0; m_pass[k] = 0; m_fail[k] = 0;
            m_mask[k] = '0; m_base[k] = 0; m_ref[k] = '0; done_cnt[k] = 0;
        end
        forever begin
            @(posedge clk or negedge rst_n);
            for (int k = 0; k < 3; k++) begin
                int n;
                int per;
                int s;
                per = lat(k) + 2;
                n   = (CW + 1) * per;
                if (!rst_n) begin
                    m_act[k] = 0; m_t[k] = 0; m_pass[k] = 0; m_fail[k] = 0;
                    m_mask[k] = '0; m_base[k] = 0; m_ref[k] = '0;
                end else if (!m_act[k]) begin
                    if (start[k]) begin
                        m_act[k] = 1; m_t[k] = 1; m_md[k] = mode; m_ref[k] = ref_data;
                        m_pass[k] = 0; m_fail[k] = 0; m_mask[k] = '0; m_base[k] = 0;
                    end
                end else if (m_t[k] <= n) begin
                    if (abort) begin
                        m_act[k] = 0;
                    end else begin
                        if (m_t[k] % per == 0) begin
                            s = m_t[k] / per - 1;
                            if (step_ok(m_md[k], s)) m_pass[k]++;
                            else begin
                                m_fail[k]++;
                                if (s == 0) m_base[k] = 1;
                                else m_mask[k][s-1] = 1'b1;
                            end
                        end
                        m_t[k]++;
                    end
                end else begin
                    m_act[k] = 0;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                int n;
                int s;
                bit steps;
                n     = (CW + 1) * (lat(k) + 2);
                s     = (m_t[k] - 1) / (lat(k) + 2);
                steps = m_act[k] && m_t[k] <= n;
                chk($sformatf("d%0d.fault_en", k), 32'(fen[k]), 32'(steps && s >= 1));
                chk($sformatf("d%0d.busy", k), 32'(busy[k]), 32'(m_act[k]));
                chk($sformatf("d%0d.done", k), 32'(done[k]), 32'(m_act[k] && m_t[k] == n + 1));
                chk($sformatf("d%0d.enc_data", k), 32'(enc[k]), 32'(m_ref[k]));
                chk($sformatf("d%0d.pass_cnt", k), 32'(pc[k]), 32'(m_pass[k]));
                chk($sformatf("d%0d.fail_cnt", k), 32'(fc[k]), 32'(m_fail[k]));
                chk($sformatf("d%0d.fail_mask", k), 32'(mask[k]), 32'(m_mask[k]));
                chk($sformatf("d%0d.baseline_fail", k), 32'(base[k]), 32'(m_base[k]));
                if (steps) chk($sformatf("d%0d.fault_bit_addr", k), 32'(addr[k]), 32'((s >= 1) ? s - 1 : 0));
                if (done[k] === 1'b1) done_cnt[k]++;
            end
        end
    end

    // Returns the cycle (start cycle = 1) in which done was seen, or limit if it never came.
    task automatic campaign(input int k, input logic [7:0] data, input int md,
                            input int abort_at, input int dup_at, input int limit, output int cyc);
        mode     = md;
        ref_data = data;
        done_cnt[k] = 0;
        @(posedge clk); #2;
        start[k] = 1'b1;
        @(posedge clk); #2;
        start[k] = 1'b0;
        ref_data = ~data;
        cyc = 1;
        while (cyc < limit) begin
            abort    = (cyc == abort_at);
            start[k] = (cyc == dup_at);
            @(negedge clk);
            if (done[k] === 1'b1) break;
            @(posedge clk);
            cyc++;
            #2;
        end
        abort    = 1'b0;
        start[k] = 1'b0;
    endtask

    task automatic settle();
        repeat (3) @(posedge clk);
        #2;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int c;
        rst_n = 1'b1; start = '0; abort = 1'b0; ref_data = '0; mode = 0;
        #1 rst_n = 1'b0;
        #2;
        chk("reset.enc_data", 32'(enc[0]), 32'h0);
        chk("reset.fault_en", 32'(fen[0]), 32'h0);
        chk("reset.addr", 32'(addr[0]), 32'h0);
        chk("reset.busy", 32'(busy[0]), 32'h0);
        chk("reset.done", 32'(done[0]), 32'h0);
        chk("reset.counts", 32'({pc[0], fc[0]}), 32'h0);
        chk("reset.mask", 32'({base[0], mask[0]}), 32'h0);
        @(posedge clk); #2 rst_n = 1'b1;

        campaign(0, 8'hA5, 0, -1, -1, 100, c);
        chk("ideal.done_cycle", 32'(c), 32'd40);
        settle();
        chk("ideal.pass_cnt", 32'(pc[0]), 32'd13);
        chk("ideal.fail_cnt", 32'(fc[0]), 32'd0);
        chk("ideal.fail_mask", 32'(mask[0]), 32'h000);
        chk("ideal.baseline_fail", 32'(base[0]), 32'd0);
        chk("ideal.enc_data", 32'(enc[0]), 32'hA5);
        chk("ideal.done_pulses", 32'(done_cnt[0]), 32'd1);

        campaign(0, 8'h3C, 1, -1, -1, 100, c);
        settle();
        chk("miscorr.pass_cnt", 32'(pc[0]), 32'd12);
        chk("miscorr.fail_cnt", 32'(fc[0]), 32'd1);
        chk("miscorr.fail_mask", 32'(mask[0]), 32'h020);
        chk("miscorr.baseline_fail", 32'(base[0]), 32'd0);

        campaign(0, 8'h81, 2, -1, -1, 100, c);
        settle();
        chk("errstuck.baseline_fail", 32'(base[0]), 32'd1);
        chk("errstuck.fail_cnt", 32'(fc[0]), 32'd1);
        chk("errstuck.pass_cnt", 32'(pc[0]), 32'd12);
        chk("errstuck.fail_mask", 32'(mask[0]), 32'h000);

        campaign(0, 8'h5A, 0, 15, -1, 30, c);
        chk("abort.busy", 32'(busy[0]), 32'd0);
        chk("abort.fault_en", 32'(fen[0]), 32'd0);
        chk("abort.pass_cnt", 32'(pc[0]), 32'd4);
        chk("abort.fail_cnt", 32'(fc[0]), 32'd0);
        chk("abort.done_pulses", 32'(done_cnt[0]), 32'd0);

        campaign(0, 8'hC3, 0, -1, 10, 100, c);
        chk("dupstart.done_cycle", 32'(c), 32'd40);
        settle();
        chk("dupstart.done_pulses", 32'(done_cnt[0]), 32'd1);
        chk("dupstart.enc_data", 32'(enc[0]), 32'hC3);

        campaign(0, 8'h96, 0, -1, -1, 5, c);
        chk("midwait.pass_cnt", 32'(pc[0]), 32'd1);
        chk("midwait.fault_en", 32'(fen[0]), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("areset.busy", 32'(busy[0]), 32'd0);
        chk("areset.fault_en", 32'(fen[0]), 32'd0);
        chk("areset.counts", 32'({pc[0], fc[0]}), 32'h0);
        chk("areset.enc_data", 32'(enc[0]), 32'h0);
        @(posedge clk); #2 rst_n = 1'b1;
        settle();
        chk("areset.done_pulses", 32'(done_cnt[0]), 32'd0);

        campaign(1, 8'h0F, 0, -1, -1, 100, c);
        chk("lat3.done_cycle", 32'(c), 32'd66);
        settle();
        chk("lat3.pass_cnt", 32'(pc[1]), 32'd13);

        campaign(2, 8'hF0, 0, -1, -1, 100, c);
        chk("lat0.done_cycle", 32'(c), 32'd27);
        settle();
        chk("lat0.pass_cnt", 32'(pc[2]), 32'd13);
        chk("lat0.fail_cnt", 32'(fc[2]), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
